// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle over a shared 2*DATA_WIDTH accumulator.
module muldiv_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LAST    = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                  state, state_nxt;
    logic [2:0]              op_q;
    logic                    neg_q;
    logic [DATA_WIDTH-1:0]   opnd_q;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]    cnt;

    logic                    accept;
    logic                    special;
    logic [DATA_WIDTH-1:0]   spec_res;
    logic                    a_neg, b_neg;
    logic                    use_sa, use_sb, neg_in;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;

    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH:0]     rem_sh;
    logic [DATA_WIDTH:0]     diff;
    logic [2*DATA_WIDTH-1:0] acc_nxt;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   div_raw;
    logic [DATA_WIDTH-1:0]   fin_res;

    assign accept = (state == IDLE) && start && !flush;

    // Operand conditioning: signed ops work on magnitudes, sign restored at the end
    always_comb begin
        a_neg  = src_a[DATA_WIDTH-1];
        b_neg  = src_b[DATA_WIDTH-1];
        use_sa = 1'b0;
        use_sb = 1'b0;
        neg_in = 1'b0;
        case (op)
            3'b001, 3'b100: begin use_sa = 1'b1; use_sb = 1'b1; neg_in = a_neg ^ b_neg; end
            3'b010:         begin use_sa = 1'b1; neg_in = a_neg; end
            3'b110:         begin use_sa = 1'b1; use_sb = 1'b1; neg_in = a_neg; end
            default:        ;
        endcase
        mag_a = (use_sa && a_neg) ? -src_a : src_a;
        mag_b = (use_sb && b_neg) ? -src_b : src_b;
    end

    always_comb begin
        special  = 1'b0;
        spec_res = '0;
        if (op[2] && src_b == '0) begin
            special  = 1'b1;
            spec_res = op[1] ? src_a : '1;
        end else if (op[2] && !op[0] && src_a == MIN_NEG && src_b == '1) begin
            special  = 1'b1;
            spec_res = op[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration; acc holds {partial_hi, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        sum     = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
        diff    = rem_sh - {1'b0, opnd_q};
        acc_nxt = '0;
        if (!op_q[2]) begin
            acc_nxt = {sum, acc[DATA_WIDTH-1:1]};
        end else if (!diff[DATA_WIDTH]) begin
            acc_nxt = {diff[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {rem_sh[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b0};
        end
        prod    = neg_q ? -acc_nxt : acc_nxt;
        div_raw = op_q[1] ? acc_nxt[2*DATA_WIDTH-1:DATA_WIDTH] : acc_nxt[DATA_WIDTH-1:0];
        if (!op_q[2]) begin
            fin_res = (op_q[1:0] == 2'b00) ? prod[DATA_WIDTH-1:0] : prod[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
            fin_res = neg_q ? -div_raw : div_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: begin
                if (flush)             state_nxt = IDLE;
                else if (cnt == LAST)  state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                valid     = !flush;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q   <= op;
                    neg_q  <= neg_in;
                    cnt    <= '0;
                    opnd_q <= op[2] ? mag_b : mag_a;
                    acc    <= {{DATA_WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
                    if (special) result <= spec_res;
                end
                CALC: if (!flush) begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) result <= fin_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: latency, results, specials, flush, reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, valid;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    muldiv_seq #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .valid(valid), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for valid, check latency/result/busy and the hold afterwards
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        logic busy_ok;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; src_a = ~a; src_b = ~b ^ 32'h5; op = ~o;
        lat = 1; busy_ok = 1'b1;
        while (valid !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp_r);
        check({tag, "_busy_held"}, {31'd0, busy_ok & busy}, 32'd1);
        @(negedge clk);
        check({tag, "_after"}, {29'd0, valid, busy, 1'b0}, 32'd0);
        check({tag, "_hold"}, result, exp_r);
    endtask

    initial begin
        int lat;
        logic seen;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, valid, 30'd0}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;

        do_op("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        do_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("div",      3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        do_op("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        do_op("rem_posa", 3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,        33);
        do_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       33);
        do_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        33);
        do_op("divu_z",   3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        do_op("rem_z",    3'b110, 32'd5,        32'd0,        32'd5,         1);
        do_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // start while busy must be ignored
        @(negedge clk);
        op = 3'b101; src_a = 32'd1000; src_b = 32'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (valid !== 1'b1 && lat < 40) begin
            start = (lat == 10);
            if (start) begin op = 3'b000; src_a = 32'd3; src_b = 32'd3; end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("busy_start_latency", lat, 33);
        check("busy_start_result", result, 32'd100);
        @(negedge clk);
        check("busy_start_idle", {31'd0, busy}, 32'd0);

        // flush mid-divide: no pulse, result unchanged
        @(negedge clk);
        op = 3'b100; src_a = 32'hFFFF_FF9C; src_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_valid", {31'd0, valid}, 32'd0);
        check("flush_result", result, 32'd100);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("flush_no_pulse", {31'd0, seen}, 32'd0);

        // flush coincident with DONE cancels the pulse
        @(negedge clk);
        op = 3'b101; src_a = 32'd9; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        check("done_flush_latency", lat, 33);
        flush = 1'b1;
        #1;
        check("done_flush_valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("done_flush_idle", {31'd0, busy}, 32'd0);

        // start with flush in IDLE is dropped
        @(negedge clk);
        op = 3'b000; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_start", {30'd0, busy, valid}, 32'd0);

        // reset mid-multiply
        @(negedge clk);
        op = 3'b000; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_flags", {30'd0, busy, valid}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        do_op("mul_after_rst", 3'b000, 32'd6, 32'd7, 32'd42, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
